// File: rtl/button_select_pkg.sv
// Shared types and default timing constants for the button mode selector.
package button_select_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD_NEXT = 2'd1,
        HELD_PREV = 2'd2,
        HELD_BOTH = 2'd3
    } sel_state_t;

    // Defaults assume a 50 MHz clock: 10 ms debounce, 0.5 s first repeat, 0.2 s repeat rate.
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int REPEAT_DELAY_DEF    = 25000000;
    localparam int REPEAT_PERIOD_DEF   = 10000000;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for one push button.
module button_debounce #(
    parameter  int CYCLES = 4,
    localparam int CNT_W  = $clog2(CYCLES + 1)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic button_raw,
    output logic level
);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: Reset is sampled on the clock edge, not in the sensitivity list.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so both synchroniser stages sample the old values.
            sync1_q <= button_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_mode_select.sv
// Two-button wrap-around mode selector; both buttons held forces mode 0.
// Define BUTTON_MODE_SELECT_AUTOREPEAT_EN to auto-step while a single button is held.
module button_mode_select
    import button_select_pkg::*;
#(
    parameter  int NUM_MODES       = 4,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter  int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter  int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    localparam int MODE_W          = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              button_next,
    input  logic              button_prev,
    output logic [MODE_W-1:0] function_select,
    output logic              mode_changed
);

    localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_MODES - 1);

    logic              n_db, p_db;
    sel_state_t        state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              changed_q, changed_d;
    logic              step_up, step_dn, force_zero;

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .Clk        (Clk),
        .Reset      (Reset),
        .button_raw (button_next),
        .level      (n_db)
    );

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .Clk        (Clk),
        .Reset      (Reset),
        .button_raw (button_prev),
        .level      (p_db)
    );

`ifdef BUTTON_MODE_SELECT_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              stepped_q, stepped_d;
    logic              hold_active;
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        changed_d  = 1'b0;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        force_zero = 1'b0;
`ifdef BUTTON_MODE_SELECT_AUTOREPEAT_EN
        hold_cnt_d  = '0;
        stepped_d   = 1'b0;
        hold_active = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (n_db && p_db)  state_d = HELD_BOTH;
                else if (n_db)     state_d = HELD_NEXT;
                else if (p_db)     state_d = HELD_PREV;
            end
            HELD_NEXT: begin
                if (p_db) begin
                    state_d = HELD_BOTH;
                end else if (!n_db) begin
                    state_d = IDLE;
`ifdef BUTTON_MODE_SELECT_AUTOREPEAT_EN
                    step_up = !stepped_q;
                end else begin
                    hold_active = 1'b1;
`else
                    step_up = 1'b1;
`endif
                end
            end
            HELD_PREV: begin
                if (n_db) begin
                    state_d = HELD_BOTH;
                end else if (!p_db) begin
                    state_d = IDLE;
`ifdef BUTTON_MODE_SELECT_AUTOREPEAT_EN
                    step_dn = !stepped_q;
                end else begin
                    hold_active = 1'b1;
`else
                    step_dn = 1'b1;
`endif
                end
            end
            HELD_BOTH: begin
                if (!n_db && !p_db) begin
                    state_d    = IDLE;
                    force_zero = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef BUTTON_MODE_SELECT_AUTOREPEAT_EN
        // Counter survives only while staying in a single-button hold state.
        if (hold_active) begin
            stepped_d  = stepped_q;
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if ((!stepped_q && hold_cnt_q == HOLD_W'(REPEAT_DELAY - 1)) ||
                ( stepped_q && hold_cnt_q == HOLD_W'(REPEAT_PERIOD - 1))) begin
                hold_cnt_d = '0;
                stepped_d  = 1'b1;
                step_up    = (state_q == HELD_NEXT);
                step_dn    = (state_q == HELD_PREV);
            end
        end
`endif

        if (force_zero) begin
            mode_d    = '0;
            changed_d = (mode_q != '0);
        end else if (step_up) begin
            mode_d    = (mode_q >= MAX_MODE) ? '0 : mode_q + MODE_W'(1);
            changed_d = 1'b1;
        end else if (step_dn) begin
            mode_d    = (mode_q == '0 || mode_q > MAX_MODE) ? MAX_MODE : mode_q - MODE_W'(1);
            changed_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            changed_q <= changed_d;
        end
    end

`ifdef BUTTON_MODE_SELECT_AUTOREPEAT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_cnt_q <= '0;
            stepped_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            stepped_q  <= stepped_d;
        end
    end
`endif

    assign function_select = mode_q;
    assign mode_changed    = changed_q;

endmodule

// File: tb/tb_button_mode_select.sv
// Directed self-checking bench for button_mode_select (NUM_MODES=5, debounce 4 cycles).
module tb_button_mode_select;

    localparam int NUM_MODES = 5;
    localparam int MODE_W    = $clog2(NUM_MODES);

    logic              Clk = 1'b0;
    logic              Reset;
    logic              button_next;
    logic              button_prev;
    logic [MODE_W-1:0] function_select;
    logic              mode_changed;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulse_start;

    button_mode_select #(
        .NUM_MODES       (NUM_MODES),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .button_next     (button_next),
        .button_prev     (button_prev),
        .function_select (function_select),
        .mode_changed    (mode_changed)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (mode_changed) pulses = pulses + 1;
        if (int'(function_select) >= NUM_MODES) begin
            $display("FAIL range: function_select=%0d, required < %0d", function_select, NUM_MODES);
            errors = errors + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic mark();
        tick(1);
        pulse_start = pulses;
    endtask

    task automatic press_release(input bit is_next, input int hold_cycles);
        if (is_next) button_next = 1'b1; else button_prev = 1'b1;
        tick(hold_cycles);
        if (is_next) button_next = 1'b0; else button_prev = 1'b0;
        tick(10);
    endtask

    initial begin
        Reset       = 1'b1;
        button_next = 1'b0;
        button_prev = 1'b0;
        tick(3);
        check("reset_mode", int'(function_select), 0);
        check("reset_pulse", int'(mode_changed), 0);
        Reset = 1'b0;

        // 1: step up four times, fifth wraps to 0
        for (int i = 1; i <= 5; i++) begin
            mark();
            button_next = 1'b1;
            tick(10);
            check("next_press_hold", int'(function_select), i - 1);
            button_next = 1'b0;
            tick(10);
            check("next_release_mode", int'(function_select), i % NUM_MODES);
            check("next_release_pulses", pulses - pulse_start, 1);
        end

        // 2: step down from 0 wraps to NUM_MODES-1
        mark();
        button_prev = 1'b1;
        tick(10);
        check("prev_press_hold", int'(function_select), 0);
        button_prev = 1'b0;
        tick(10);
        check("prev_wrap_mode", int'(function_select), 4);
        check("prev_wrap_pulses", pulses - pulse_start, 1);

        // 3: bouncing input never qualifies
        mark();
        for (int i = 0; i < 10; i++) begin
            button_next = ~button_next;
            tick(2);
        end
        button_next = 1'b0;
        tick(10);
        check("bounce_mode", int'(function_select), 4);
        check("bounce_pulses", pulses - pulse_start, 0);

        // 4: reach mode 3, then both buttons force 0
        for (int i = 0; i < 4; i++) press_release(1'b1, 10);
        check("setup_mode3", int'(function_select), 3);
        for (int rep = 0; rep < 2; rep++) begin
            mark();
            button_next = 1'b1;
            tick(10);
            button_prev = 1'b1;
            tick(10);
            button_next = 1'b0;
            tick(10);
            check("both_hold_mode", int'(function_select), rep == 0 ? 3 : 0);
            button_prev = 1'b0;
            tick(10);
            check("both_release_mode", int'(function_select), 0);
            check("both_release_pulses", pulses - pulse_start, rep == 0 ? 1 : 0);
        end

        // 5: reset while next held; held button re-qualifies as a fresh press
        press_release(1'b1, 10);
        press_release(1'b1, 10);
        check("setup_mode2", int'(function_select), 2);
        button_next = 1'b1;
        tick(10);
        Reset = 1'b1;
        tick(1);
        check("midhold_reset_mode", int'(function_select), 0);
        check("midhold_reset_pulse", int'(mode_changed), 0);
        Reset = 1'b0;
        mark();
        tick(10);
        check("post_reset_hold_mode", int'(function_select), 0);
        button_next = 1'b0;
        tick(10);
        check("post_reset_release_mode", int'(function_select), 1);
        check("post_reset_release_pulses", pulses - pulse_start, 1);

        // 6: long hold from mode 0
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        check("reset2_mode", int'(function_select), 0);
        mark();
        press_release(1'b1, 40);
`ifdef BUTTON_MODE_SELECT_AUTOREPEAT_EN
        check("long_hold_mode", int'(function_select), 3);
        check("long_hold_pulses", pulses - pulse_start, 3);
`else
        check("long_hold_mode", int'(function_select), 1);
        check("long_hold_pulses", pulses - pulse_start, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
